stream_demux1x2: RTL
====================

Name: stream_demux1x2

Overview:
- Packet-aware 1-to-2 stream demultiplexer. It is the splitting counterpart of the 2:1 selection path.
- Accepts one valid/ready input stream and routes each whole packet to output 0 or output 1, chosen by in_sel on the packet's first beat.
- Each output has its own FIFO, so a stalled consumer never blocks packets bound for the other output.
- Sits between a producer and two independent consumers in the datapath/lab-bus fabric.

Parameters:
- WIDTH, 8, data bits per beat.
- DEPTH, 2, entries per output FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a beat on in_data.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  beat payload.
- in_sel  input  1  destination (0 or 1); sampled only on a packet's first beat.
- in_last  input  1  marks the final beat of a packet.
- out0_valid  output  1  output 0 FIFO non-empty.
- out0_ready  input  1  consumer 0 takes the head beat.
- out0_data  output  WIDTH  head beat payload, output 0.
- out0_last  output  1  head beat last flag, output 0.
- out1_valid, out1_ready, out1_data, out1_last: same as the output 0 group, for output 1.
- busy  output  1  high when the FSM is in ROUTE or either FIFO is non-empty.

Behaviour:
- Handshake: a beat transfers on a rising edge where valid and ready are both high. The same rule applies on the input and both outputs.
- Route FSM states: IDLE, ROUTE. Register dest (1 bit).
  - IDLE: effective destination = in_sel.
    - Accepted beat with in_last=1: stay IDLE (single-beat packet).
    - Accepted beat with in_last=0: dest <= in_sel, go to ROUTE.
  - ROUTE: effective destination = dest; in_sel is ignored.
    - Accepted beat with in_last=1: go to IDLE.
    - Accepted beat with in_last=0: stay in ROUTE.
  - No beat accepted: state and dest hold.
- in_ready = NOT full(effective destination FIFO).
  - Combinational from FSM state, dest, in_sel and FIFO occupancy only.
  - Independent of in_valid and of outX_ready. A full FIFO refuses a push even while it is being popped in the same cycle.
- FIFOs (one per output):
  - Each entry stores {last, data}.
  - Read/write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
  - Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
  - Push and pop in the same cycle are legal whenever the FIFO is non-empty and non-full; occupancy is then unchanged.
  - Show-ahead: outX_data and outX_last come combinationally from the head entry. outX_valid = NOT empty.
- Latency: a beat accepted at edge N is visible on outX_valid from just after edge N (one cycle).
- Throughput: with DEPTH>=2 and the consumer always ready, sustained rate is 1 beat/cycle.
- Isolation: in IDLE, a packet to the non-full output proceeds even if the other FIFO is full.
- Ordering: beats within each output appear in input order. Packets are never interleaved on an output.
- Reset (asynchronous, takes effect immediately):
  - State = IDLE, dest = 0.
  - All pointers = 0, so both FIFOs are empty.
  - Storage = 0; out0_valid = out1_valid = 0; out0/1_data = 0; out0/1_last = 0; busy = 0.
  - in_ready = 1 after reset, because both FIFOs are empty.
  - Reset mid-packet discards all buffered and partial beats; the next accepted beat is treated as a first beat.
- No error detection: a packet without in_last keeps the FSM in ROUTE indefinitely.

Test Plan:
- Single-beat packets: after reset, send data 0x11 with sel=0, last=1, then 0x22 with sel=1, last=1, consumers ready. Required: out0 shows 0x11/last=1 one cycle after acceptance; out1 shows 0x22/last=1 one cycle after its acceptance; busy returns to 0.
- Packet lock: 3-beat packet 0xA0, 0xA1, 0xA2 (last on 0xA2), sel=1 on the first beat, sel toggled to 0 on beats 2 and 3. Required: all three beats appear on out1 in order; out0_valid stays 0.
- Backpressure/full: out0_ready=0, send three beats to out0 with DEPTH=2. Required: in_ready drops after two acceptances. Raising out0_ready drains 2 beats, then the third is accepted and emitted.
- Isolation: out0 FIFO full and state IDLE, then send packet 0x55 with sel=1, last=1. Required: accepted immediately and appears on out1.
- Throughput: stream 8 beats to out1 with out1_ready=1 throughout. Required: in_ready stays 1 and out1 emits 8 consecutive beats with no bubbles.
- Reset mid-packet: assert rst after beat 2 of a 4-beat packet to out0. Required: both valids go 0 immediately and busy=0. A following beat with sel=1, last=1 routes to out1.

Source files
------------

// File: rtl/stream_demux1x2.sv
// Packet-aware 1-to-2 stream demultiplexer with one show-ahead FIFO per output.
// A packet's destination is taken from in_sel on its first beat and held until in_last.

// Per-output FIFO holding {last, data} entries; pointers carry an extra wrap bit.
module stream_demux1x2_fifo #(
  parameter int unsigned EW    = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [EW-1:0] wdata,
  input  logic          pop,
  output logic [EW-1:0] rdata,
  output logic          empty,
  output logic          full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [EW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; a full FIFO refuses a push even while being popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage, cleared on reset so an empty head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end
endmodule

module stream_demux1x2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             busy
);
  localparam int unsigned EW = WIDTH + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          dest_q;
  logic          dest_d;
  logic          eff_dest;
  logic          accept;
  logic          full0;
  logic          full1;
  logic          empty0;
  logic          empty1;
  logic [EW-1:0] head0;
  logic [EW-1:0] head1;

  // Route state and locked destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  // Destination choice, input ready and packet tracking.
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    eff_dest = in_sel;
    in_ready = 1'b0;
    accept   = 1'b0;
    if (state_q == ROUTE) eff_dest = dest_q;
    in_ready = eff_dest ? !full1 : !full0;
    accept   = in_valid && in_ready;
    if (accept) begin
      if (state_q == IDLE) begin
        if (!in_last) begin
          state_d = ROUTE;
          dest_d  = in_sel;
        end
      end else if (in_last) begin
        state_d = IDLE;
      end
    end
  end

  stream_demux1x2_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && !eff_dest),
    .wdata ({in_last, in_data}),
    .pop   (out0_ready),
    .rdata (head0),
    .empty (empty0),
    .full  (full0)
  );

  stream_demux1x2_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && eff_dest),
    .wdata ({in_last, in_data}),
    .pop   (out1_ready),
    .rdata (head1),
    .empty (empty1),
    .full  (full1)
  );

  assign out0_valid = !empty0;
  assign out0_last  = head0[EW-1];
  assign out0_data  = head0[WIDTH-1:0];
  assign out1_valid = !empty1;
  assign out1_last  = head1[EW-1];
  assign out1_data  = head1[WIDTH-1:0];
  assign busy       = (state_q == ROUTE) || !empty0 || !empty1;
endmodule
